// File: rtl/icache_mem_arbiter.sv
// Arbitrates the single line-refill memory port between demand (dm) and prefetch (pf) requesters.
// Optional MEM_ARB_TIMEOUT_EN bounds the REQ wait and returns an error response on expiry.
module icache_mem_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned LINE_W         = 128,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dm_req_valid,
  input  logic [ADDR_W-1:0] dm_req_addr,
  output logic              dm_req_ready,
  output logic              dm_rsp_valid,
  output logic [LINE_W-1:0] dm_rsp_data,
  output logic              dm_rsp_err,
  input  logic              pf_req_valid,
  input  logic [ADDR_W-1:0] pf_req_addr,
  output logic              pf_req_ready,
  output logic              pf_rsp_valid,
  output logic [LINE_W-1:0] pf_rsp_data,
  output logic              pf_rsp_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_data,
  input  logic              mem_ready,
  output logic              busy
);
  localparam int unsigned       CNT_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(15);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             grant_id;  // 0 = dm, 1 = pf
  logic             gnt_dm, gnt_pf, done_ok, done_to, to_hit;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
  assign to_hit = (to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_hit         = 1'b0;
`endif

  // Grant decision and next-state logic
  always_comb begin
    state_nxt = state;
    gnt_dm    = 1'b0;
    gnt_pf    = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req_valid && pf_req_valid) begin
          if (starve_cnt == CNT_MAX) gnt_pf = 1'b1;
          else                       gnt_dm = 1'b1;
        end else begin
          gnt_dm = dm_req_valid;
          gnt_pf = pf_req_valid;
        end
        if (gnt_dm || gnt_pf) state_nxt = REQ;
      end
      REQ: begin
        if (mem_ready) begin
          done_ok   = 1'b1;
          state_nxt = RESP;
        end else if (to_hit) begin
          done_to   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant bookkeeping and response data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      grant_id    <= 1'b0;
      mem_addr    <= '0;
      dm_rsp_data <= '0;
      pf_rsp_data <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_dm) begin
        mem_addr <= dm_req_addr & LINE_MASK;
        grant_id <= 1'b0;
        if (!pf_req_valid)            starve_cnt <= '0;
        else if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + CNT_W'(1);
      end
      if (gnt_pf) begin
        mem_addr   <= pf_req_addr & LINE_MASK;
        grant_id   <= 1'b1;
        starve_cnt <= '0;
      end
      if (done_ok || done_to) begin
        if (grant_id) pf_rsp_data <= done_ok ? mem_data : '0;
        else          dm_rsp_data <= done_ok ? mem_data : '0;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Timeout counter runs only while waiting in REQ; error flag rides with the response
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt     <= '0;
      dm_rsp_err <= 1'b0;
      pf_rsp_err <= 1'b0;
    end else begin
      to_cnt <= (state == REQ) ? to_cnt + 16'd1 : 16'd0;
      if (done_ok || done_to) begin
        if (grant_id) pf_rsp_err <= done_to;
        else          dm_rsp_err <= done_to;
      end
    end
  end
`else
  assign dm_rsp_err = 1'b0;
  assign pf_rsp_err = 1'b0;
`endif

  assign dm_req_ready = gnt_dm;
  assign pf_req_ready = gnt_pf;
  assign mem_req      = (state == REQ);
  assign busy         = (state != IDLE);
  assign dm_rsp_valid = (state == RESP) && !grant_id;
  assign pf_rsp_valid = (state == RESP) &&  grant_id;

endmodule

// File: tb/tb_icache_mem_arbiter.sv
// Self-checking bench for icache_mem_arbiter: directed vector table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_icache_mem_arbiter;
  localparam int unsigned STARVE = 4;
  localparam int unsigned TO     = 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [127:0] D1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_1111_2222;
  localparam logic [127:0] D2 = 128'hCAFE_F00D_5555_AAAA_0F0F_F0F0_3333_4444;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, dm_req_valid, pf_req_valid, mem_ready;
  logic [31:0]  dm_req_addr, pf_req_addr;
  logic [127:0] mem_data;
  logic         dm_req_ready, dm_rsp_valid, dm_rsp_err, pf_req_ready, pf_rsp_valid, pf_rsp_err;
  logic [127:0] dm_rsp_data, pf_rsp_data;
  logic         mem_req, busy;
  logic [31:0]  mem_addr;

  icache_mem_arbiter #(.ADDR_W(32), .LINE_W(128), .STARVE_LIMIT(STARVE), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .dm_req_valid(dm_req_valid), .dm_req_addr(dm_req_addr), .dm_req_ready(dm_req_ready),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data), .dm_rsp_err(dm_rsp_err),
    .pf_req_valid(pf_req_valid), .pf_req_addr(pf_req_addr), .pf_req_ready(pf_req_ready),
    .pf_rsp_valid(pf_rsp_valid), .pf_rsp_data(pf_rsp_data), .pf_rsp_err(pf_rsp_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endfunction

  function automatic void chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endfunction

  function automatic void chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endfunction

  // Transaction-level model: one open memory transaction, then one response cycle
  bit           m_open, m_rsp, m_who, m_de, m_pe;
  logic [31:0]  m_addr;
  logic [127:0] m_dd, m_pd;
  int           m_starve, m_wait, exp_g;

  task automatic model_reset();
    m_open = 0; m_rsp = 0; m_who = 0; m_de = 0; m_pe = 0;
    m_addr = '0; m_dd = '0; m_pd = '0; m_starve = 0; m_wait = 0; exp_g = 0;
  endtask

  task automatic deliver(input logic [127:0] d, input bit e);
    m_open = 0;
    m_rsp  = 1;
    if (m_who) begin m_pd = d; m_pe = e; end
    else       begin m_dd = d; m_de = e; end
  endtask

  // Apply inputs at the falling edge and compare every output against the model
  task automatic drive(input bit r, input bit dv, input logic [31:0] da, input bit pv,
                       input logic [31:0] pa, input bit mr, input logic [127:0] md);
    bit idle;
    @(negedge clk);
    rst = r; dm_req_valid = dv; dm_req_addr = da; pf_req_valid = pv; pf_req_addr = pa;
    mem_ready = mr; mem_data = md;
    #1;
    idle  = !m_open && !m_rsp;
    exp_g = 0;
    if (idle) begin
      if (dv && pv)  exp_g = (m_starve >= int'(STARVE)) ? 2 : 1;
      else if (dv)   exp_g = 1;
      else if (pv)   exp_g = 2;
    end
    chk1("dm_req_ready", dm_req_ready, exp_g == 1);
    chk1("pf_req_ready", pf_req_ready, exp_g == 2);
    chk1("mem_req", mem_req, m_open);
    chkw("mem_addr", 128'(mem_addr), 128'(m_addr));
    chk1("busy", busy, !idle);
    chk1("dm_rsp_valid", dm_rsp_valid, m_rsp && !m_who);
    chk1("pf_rsp_valid", pf_rsp_valid, m_rsp && m_who);
    chkw("dm_rsp_data", dm_rsp_data, m_dd);
    chkw("pf_rsp_data", pf_rsp_data, m_pd);
    chk1("dm_rsp_err", dm_rsp_err, m_de);
    chk1("pf_rsp_err", pf_rsp_err, m_pe);
  endtask

  // Advance the model across the rising edge using the inputs the bench applied
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else if (m_rsp) m_rsp = 0;
    else if (m_open) begin
      if (mem_ready)                              deliver(mem_data, 1'b0);
      else if (TO_EN && m_wait == int'(TO) - 1)   deliver('0, 1'b1);
      else                                        m_wait++;
    end else if (exp_g != 0) begin
      m_open = 1;
      m_wait = 0;
      m_who  = (exp_g == 2);
      m_addr = ((exp_g == 2) ? pf_req_addr : dm_req_addr) & 32'hFFFF_FFF0;
      if (exp_g == 2)        m_starve = 0;
      else if (pf_req_valid) m_starve = (m_starve < int'(STARVE)) ? m_starve + 1 : int'(STARVE);
      else                   m_starve = 0;
    end
  endtask

  task automatic idle_step(input bit r, input bit mr);
    drive(r, 1'b0, 32'h0, 1'b0, 32'h0, mr, 128'h0);
    tick();
  endtask

  typedef struct {
    bit dv; logic [31:0] da; bit pv; logic [31:0] pa; bit mr; logic [127:0] md;
    bit e_drdy; bit e_prdy; bit e_mreq; logic [31:0] e_maddr; bit e_busy;
    bit e_drv; bit e_prv; logic [127:0] e_dd; logic [127:0] e_pd;
  } vec_t;
  vec_t vecs[11];

  int want_order[11] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2, 1};
  int order[$];
  int gcyc[$];
  int since, mreq_cnt, found;
  bit rdv, rpv, rr, rmr;
  logic [31:0]  rda, rpa;
  logic [127:0] rmd;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; dm_req_valid = 0; pf_req_valid = 0; mem_ready = 0;
    dm_req_addr = '0; pf_req_addr = '0; mem_data = '0;
    repeat (2) @(posedge clk);
    model_reset();
    idle_step(1'b1, 1'b0);
    idle_step(1'b0, 1'b0);  // reset state

    // Single demand with 3-cycle memory latency, then mem_ready held high before a pf grant
    vecs[0]  = '{1, 32'h0000_123C, 0, 0, 0, 0,  1, 0, 0, 32'h0,         0, 0, 0, 0,  0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0,              0, 0, 1, 32'h0000_1230, 1, 0, 0, 0,  0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0,              0, 0, 1, 32'h0000_1230, 1, 0, 0, 0,  0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0,              0, 0, 1, 32'h0000_1230, 1, 0, 0, 0,  0};
    vecs[4]  = '{0, 0, 0, 0, 1, D1,             0, 0, 1, 32'h0000_1230, 1, 0, 0, 0,  0};
    vecs[5]  = '{0, 0, 0, 0, 0, 0,              0, 0, 0, 32'h0000_1230, 1, 1, 0, D1, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 0,              0, 0, 0, 32'h0000_1230, 0, 0, 0, D1, 0};
    vecs[7]  = '{0, 0, 1, 32'hABCD_EF0F, 1, D2, 0, 1, 0, 32'h0000_1230, 0, 0, 0, D1, 0};
    vecs[8]  = '{0, 0, 0, 0, 1, D2,             0, 0, 1, 32'hABCD_EF00, 1, 0, 0, D1, 0};
    vecs[9]  = '{0, 0, 0, 0, 0, 0,              0, 0, 0, 32'hABCD_EF00, 1, 0, 1, D1, D2};
    vecs[10] = '{0, 0, 0, 0, 0, 0,              0, 0, 0, 32'hABCD_EF00, 0, 0, 0, D1, D2};
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, vecs[i].dv, vecs[i].da, vecs[i].pv, vecs[i].pa, vecs[i].mr, vecs[i].md);
      chk1($sformatf("v%0d_dm_rdy", i), dm_req_ready, vecs[i].e_drdy);
      chk1($sformatf("v%0d_pf_rdy", i), pf_req_ready, vecs[i].e_prdy);
      chk1($sformatf("v%0d_mem_req", i), mem_req, vecs[i].e_mreq);
      chkw($sformatf("v%0d_mem_addr", i), 128'(mem_addr), 128'(vecs[i].e_maddr));
      chk1($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      chk1($sformatf("v%0d_dm_rsp", i), dm_rsp_valid, vecs[i].e_drv);
      chk1($sformatf("v%0d_pf_rsp", i), pf_rsp_valid, vecs[i].e_prv);
      chkw($sformatf("v%0d_dm_data", i), dm_rsp_data, vecs[i].e_dd);
      chkw($sformatf("v%0d_pf_data", i), pf_rsp_data, vecs[i].e_pd);
      tick();
    end

    // Starvation: both requesters continuously valid, memory always ready
    idle_step(1'b1, 1'b0);
    for (int i = 0; i < 60 && order.size() < 11; i++) begin
      drive(1'b0, 1'b1, 32'h100 + 32'(i), 1'b1, 32'h200, 1'b1, {4{$urandom}});
      if (dm_req_ready) order.push_back(1);
      else if (pf_req_ready) order.push_back(2);
      tick();
    end
    for (int i = 0; i < 11; i++)
      chki($sformatf("starve_order%0d", i), (i < order.size()) ? order[i] : 0, want_order[i]);

    // Reset in the middle of REQ; memory answers afterwards and must be ignored
    idle_step(1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'h0000_4004, 1'b0, 32'h0, 1'b0, 128'h0); tick();
    idle_step(1'b0, 1'b0);
    idle_step(1'b0, 1'b0);
    idle_step(1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, D1);
    chk1("rst_mid_mem_req", mem_req, 1'b0);
    chk1("rst_mid_busy", busy, 1'b0);
    chk1("rst_mid_dm_rsp", dm_rsp_valid, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, D1);
    chk1("rst_mid_dm_rsp2", dm_rsp_valid, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h0000_5008, 1'b0, 32'h0, 1'b0, 128'h0);
    chk1("post_rst_grant", dm_req_ready, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, D2);
    chkw("post_rst_addr", 128'(mem_addr), 128'h5000);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 128'h0);
    chk1("post_rst_rsp", dm_rsp_valid, 1'b1);
    chkw("post_rst_data", dm_rsp_data, D2);
    tick();

    // Memory never answers a pf request
    idle_step(1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_7777, 1'b0, 128'h0); tick();
    mreq_cnt = 0;
    found    = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, D1);
      if (mem_req) mreq_cnt++;
      if (pf_rsp_valid) begin
        found = 1;
        chk1("to_err", pf_rsp_err, 1'b1);
        chkw("to_data", pf_rsp_data, 128'h0);
      end
      tick();
    end
    chki("to_found", found, TO_EN ? 1 : 0);
    chki("to_req_cycles", mreq_cnt, TO_EN ? int'(TO) : 100);
    idle_step(1'b1, 1'b0);

    // Back-to-back pf requests, memory ready in the second REQ cycle
    since = 5;
    for (int i = 0; i < 20; i++) begin
      since++;
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h3000 + 32'(i * 16), since == 2, {4{$urandom}});
      if (pf_req_ready) begin
        gcyc.push_back(i);
        since = 0;
      end
      tick();
    end
    for (int k = 1; k < 4; k++)
      chki($sformatf("b2b_gap%0d", k), (gcyc.size() > k) ? gcyc[k] - gcyc[k-1] : 0, 4);
    idle_step(1'b0, 1'b0);
    idle_step(1'b0, 1'b0);

    // Randomized traffic; requesters hold valid until granted, addresses may wander
    rdv = 0;
    rpv = 0;
    for (int i = 0; i < 2000; i++) begin
      rr  = ($urandom_range(0, 299) == 0);
      rmr = ($urandom_range(0, 2) == 0);
      rmd = {$urandom, $urandom, $urandom, $urandom};
      if (!rdv) rdv = ($urandom_range(0, 1) == 1);
      if (!rpv) rpv = ($urandom_range(0, 1) == 1);
      rda = $urandom;
      rpa = $urandom;
      drive(rr, rdv, rda, rpv, rpa, rmr, rmd);
      tick();
      if (!rr && exp_g == 1) rdv = 0;
      if (!rr && exp_g == 2) rpv = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
